regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised multi-port integer register file, successor to the 2-read/1-write RV32I register file, for superscalar and dual-issue core variants. It supports:
- configurable register width and count;
- configurable number of read and write ports, with deterministic write-port priority;
- a hardware clear sequencer that zeroes the array after reset or on request, gated by a `ready` flag.

Register 0 is hardwired to zero.

## Interface
Parameters:
- `XLEN`, 32, register width in bits.
- `NUM_REGS`, 32, register count; power of two, 4..64; `AW = $clog2(NUM_REGS)`.
- `NUM_READ`, 2, read ports, 1..6.
- `NUM_WRITE`, 2, write ports, 1..3.

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `rd_addr`  in  `NUM_READ*AW`  read addresses; port i at `[i*AW +: AW]`.
- `rd_data`  out  `NUM_READ*XLEN`  read data, combinational; port i at `[i*XLEN +: XLEN]`.
- `wr_en`  in  `NUM_WRITE`  per-port write enable.
- `wr_addr`  in  `NUM_WRITE*AW`  write addresses.
- `wr_data`  in  `NUM_WRITE*XLEN`  write data.
- `clear_req`  in  1  request a full re-clear; single-cycle pulse or level.
- `ready`  out  1  registered; 1 when the array is valid and writes are accepted.
- `wr_conflict`  out  1  registered one-cycle pulse; flags two or more enabled write ports targeting the same nonzero address in the previous cycle.

## Operation
State machine (2 states): `CLEAR`, `READY`. A clear counter `clr_idx` (AW bits) drives the sequence.

- **Reset** (`reset_n`=0, asynchronous): state=`CLEAR`, `clr_idx`=1, `ready`=0, `wr_conflict`=0. Array contents are not reset directly; the clear sequence zeroes them.
- **CLEAR**, each rising edge:
  - writes 0 to `registers[clr_idx]` and increments `clr_idx`;
  - when `clr_idx`==`NUM_REGS-1`, writes it, moves to `READY` and sets `ready`=1 on the same edge;
  - all `wr_en` are ignored;
  - all `rd_data` read 0;
  - `wr_conflict` stays 0;
  - `clear_req` restarts the sequence: `clr_idx`=1.
- **READY**, `clear_req`=1: on the next edge state=`CLEAR`, `clr_idx`=1, `ready`=0. All writes presented in that cycle are discarded.
- **READY**, normal writes: each enabled port with nonzero address writes on the rising edge. Writes to address 0 are dropped silently.
- **Same-address writes**: if several enabled ports target the same address, the highest-index port wins. If that address is nonzero, `wr_conflict`=1 for the following cycle.
- **Reads**:
  - `rd_addr`==0 always returns 0;
  - otherwise returns the stored value, subject to the bypass rule in Configuration;
  - all read ports are independent and may alias one another.
- **Out-of-range addresses**: none exist, because `NUM_REGS` is a power of two.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr` and the array).
- Write latency: value is stored at the rising edge and visible to an unbypassed read in the next cycle.
- Clear duration: `NUM_REGS-1` rising edges after reset release or `clear_req` sampling. For 32 registers, `ready` rises at edge 31 after release.
- `ready` and `wr_conflict` change only on `clk` edges or asynchronous reset.
- Reset asserted mid-clear or mid-write: immediate return to the reset state. Array contents at that point are unspecified until the clear completes.
- `clear_req` and reset release on the same edge: one clear sequence, starting at `clr_idx`=1.

## Configuration
Macro: `REGFILE_BYPASS_EN`.
- **Defined:** in `READY`, a read of nonzero address A returns the `wr_data` of the highest-index port with `wr_en`=1 and `wr_addr`==A in the same cycle (write-to-read forwarding). This resolves the same-cycle writeback/decode hazard.
- **Undefined:** reads always return the stored array value; the new value appears the cycle after the write.
- **Both cases:** no bypass in `CLEAR`, and no bypass for address 0.

## Test plan
- **Reset and clear:** release reset with defaults. Require `ready`=0 for edges 1..30 and `ready`=1 after edge 31. Require all 32 read addresses to return 0x00000000.
- **Dual write, distinct addresses:** port0 writes x5=0xDEADBEEF and port1 writes x6=0x12345678 in one cycle. Next cycle, reading x5/x6 returns those values and `wr_conflict`=0.
- **Write collision:** port0 writes x7=0x1111 and port1 writes x7=0x2222. Next cycle x7 reads 0x2222 and `wr_conflict`=1 for exactly one cycle. Repeat at x0: x0 reads 0 and `wr_conflict` stays 0.
- **Bypass:** port1 writes x9=0xCAFE while read port 0 reads x9 in the same cycle. With `REGFILE_BYPASS_EN` defined, `rd_data` is 0xCAFE that cycle. Undefined, it shows the old value, then 0xCAFE next cycle.
- **Re-clear:** load x1..x31 with nonzero values, pulse `clear_req` together with a write to x3=0x55. Require `ready`=0 next cycle, the x3 write discarded, every register 0 when `ready` returns after 31 edges, and writes ignored throughout.
- **Reset mid-clear:** assert `reset_n`=0 asynchronously at clear edge 10. Require `ready`=0 immediately, then a full 31-edge clear after release.

Source files
------------

// File: rtl/regfile_multiport.sv
// Purpose: parametrised multi-port register file with x0 hardwired to zero and a hardware clear sequencer; optional macro REGFILE_BYPASS_EN.
// Latency: reads are combinational (0 cycles); writes land on the rising edge; clear takes NUM_REGS-1 edges.
// Backpressure: while ready=0 (clearing) writes are dropped and reads return 0; there is no stall path.
module regfile_multiport #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_READ*AW-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]  rd_data,
    input  logic [NUM_WRITE-1:0]      wr_en,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data,
    input  logic                      clear_req,
    output logic                      ready,
    output logic                      wr_conflict
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] registers [NUM_REGS];
    logic            conflict_nxt;

    // Detect two or more enabled write ports aimed at the same nonzero register.
    always_comb begin
        conflict_nxt = 1'b0;
        for (int i = 0; i < NUM_WRITE; i++) begin
            for (int j = i + 1; j < NUM_WRITE; j++) begin
                if (wr_en[i] && wr_en[j] &&
                    (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &&
                    (wr_addr[i*AW +: AW] != '0)) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Clear/ready sequencer with registered ready and conflict flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CLEAR;
            clr_idx     <= FIRST_IDX;
            ready       <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_conflict <= 1'b0;
                    if (clear_req) begin
                        clr_idx <= FIRST_IDX;
                    end else if (clr_idx == LAST_IDX) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                READY: begin
                    if (clear_req) begin
                        state       <= CLEAR;
                        clr_idx     <= FIRST_IDX;
                        ready       <= 1'b0;
                        wr_conflict <= 1'b0;
                    end else begin
                        wr_conflict <= conflict_nxt;
                    end
                end
                default: begin
                    state <= CLEAR;
                    clr_idx <= FIRST_IDX;
                    ready <= 1'b0;
                    wr_conflict <= 1'b0;
                end
            endcase
        end
    end

    // Array update: zero one entry per edge while clearing, otherwise apply
    // writes in ascending port order so the highest-index port wins a tie.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            registers[clr_idx] <= '0;
        end else if (!clear_req) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    registers[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports; x0 and the clearing phase always read zero.
    always_comb begin : read_ports
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        rd_data = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            ra  = rd_addr[r*AW +: AW];
            val = registers[ra];
`ifdef REGFILE_BYPASS_EN
            // Forward same-cycle write data; later ports override earlier ones.
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                    val = wr_data[w*XLEN +: XLEN];
                end
            end
`endif
            if ((state != READY) || (ra == '0)) begin
                val = '0;
            end
            rd_data[r*XLEN +: XLEN] = val;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed stimulus pushes expectations into a queue.
// A negedge monitor pops and compares entries tagged with the current cycle.
// Bypass expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_multiport;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 clear_req;
    logic                 ready;
    logic                 wr_conflict;

    regfile_multiport #(
        .XLEN(XLEN), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_WRITE(NWR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .ready(ready), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 rd_data, 1 ready, 2 wr_conflict
        int          port;
        int          addr;
        logic [31:0] exp;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    string       nm;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Monitor: compare every expectation due in this cycle against the DUT.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       begin act = rd_data[e.port*XLEN +: XLEN]; nm = "rd_data"; end
                1:       begin act = {31'b0, ready};               nm = "ready"; end
                default: begin act = {31'b0, wr_conflict};         nm = "wr_conflict"; end
            endcase
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s port%0d x%0d: entry for cycle %0d missed (now %0d)",
                         nm, e.port, e.addr, e.cyc, cyc);
            end else if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s port%0d x%0d cycle %0d: got %h expected %h",
                         nm, e.port, e.addr, cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input int p, input int a, input logic [31:0] v);
        rd_addr[p*AW +: AW] = AW'(a);
        sb.push_back('{0, p, a, v, cyc});
    endtask

    task automatic exp_rdy(input logic v);
        sb.push_back('{1, 0, 0, {31'b0, v}, cyc});
    endtask

    task automatic exp_cfl(input logic v);
        sb.push_back('{2, 0, 0, {31'b0, v}, cyc});
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] v);
        wr_en[p]                = 1'b1;
        wr_addr[p*AW +: AW]     = AW'(a);
        wr_data[p*XLEN +: XLEN] = v;
    endtask

    task automatic wr_off();
        wr_en = '0;
    endtask

    // Walk edges 1..31 of a clear: ready low until edge 31, reads forced to 0.
    task automatic expect_clear();
        for (int k = 1; k <= NR - 1; k++) begin
            tick();
            if (k == NR - 1) wr_off();
            exp_rdy(k == NR - 1);
            exp_cfl(1'b0);
            exp_rd(0, 3, 32'h0);
        end
    endtask

    task automatic check_all_zero();
        for (int a = 0; a < NR; a++) begin
            exp_rd(0, a, 32'h0);
            exp_rd(1, NR - 1 - a, 32'h0);
            tick();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;

        // Reset state, then release and run the power-up clear.
        tick();
        exp_rdy(1'b0);
        exp_cfl(1'b0);
        reset_n = 1'b1;
        expect_clear();
        check_all_zero();

        // Dual write to distinct registers.
        wr(0, 5, 32'hDEADBEEF);
        wr(1, 6, 32'h12345678);
        tick();
        wr_off();
        exp_rd(0, 5, 32'hDEADBEEF);
        exp_rd(1, 6, 32'h12345678);
        exp_cfl(1'b0);
        tick();

        // Collision on x7: port1 wins, conflict pulses once.
        wr(0, 7, 32'h1111);
        wr(1, 7, 32'h2222);
        tick();
        wr_off();
        exp_rd(0, 7, 32'h2222);
        exp_cfl(1'b1);
        tick();
        exp_cfl(1'b0);

        // Collision on x0: dropped, no conflict.
        wr(0, 0, 32'h3333);
        wr(1, 0, 32'h4444);
        tick();
        wr_off();
        exp_rd(0, 0, 32'h0);
        exp_cfl(1'b0);
        tick();
        exp_cfl(1'b0);

        // Same-cycle write/read of x9.
        wr(1, 9, 32'hCAFE);
`ifdef REGFILE_BYPASS_EN
        exp_rd(0, 9, 32'hCAFE);
`else
        exp_rd(0, 9, 32'h0);
`endif
        tick();
        wr_off();
        exp_rd(0, 9, 32'hCAFE);
        tick();

        // Load x1..x31 with nonzero values.
        for (int a = 1; a < NR; a += 2) begin
            wr(0, a, 32'hA000_0000 | a);
            if (a + 1 < NR) wr(1, a + 1, 32'hA000_0000 | (a + 1));
            else            wr_en[1] = 1'b0;
            tick();
        end
        wr_off();
        exp_rd(0, 1, 32'hA000_0001);
        exp_rd(1, 31, 32'hA000_001F);
        tick();
        exp_rd(0, 3, 32'hA000_0003);
        exp_rd(1, 30, 32'hA000_001E);
        tick();

        // Re-clear with a simultaneous write that must be discarded;
        // colliding writes held throughout the clear must be ignored.
        wr(0, 3, 32'h55);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        exp_rdy(1'b0);
        exp_cfl(1'b0);
        wr(0, 3, 32'h77);
        wr(1, 3, 32'h88);
        expect_clear();
        check_all_zero();

        // Reset asserted at clear edge 10.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        #2;
        reset_n = 1'b0;
        exp_rdy(1'b0);
        tick();
        reset_n = 1'b1;
        expect_clear();
        wr(0, 10, 32'hBEEF0010);
        tick();
        wr_off();
        exp_rd(0, 10, 32'hBEEF0010);
        exp_rd(1, 5, 32'h0);
        tick();

        // Reset while READY: ready drops without waiting for an edge.
        #2;
        reset_n = 1'b0;
        exp_rdy(1'b0);
        tick();
        reset_n = 1'b1;
        expect_clear();
        exp_rd(0, 10, 32'h0);
        tick();

        tick();
        tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations never compared", sb.size());
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
